xvga_sync_decoder: RTL
======================

// Module: xvga_sync_decoder
// PURPOSE
//  Receive side of the XVGA timing interface. Recovers pixel position from
//  incoming hsync/vsync (external source or loopback of our own XVGA output).
//  Outputs hcount/vcount/active aligned to the xvga generator's convention,
//  measures line and frame length, and reports lock. Sits between the video
//  input pins (PMOD/JB) and the capture/overlay logic, in the 65 MHz pixel domain.
// PARAMETERS
//  SYNC_ACT_LOW  1    1: incoming syncs are active-low (as driven on VGA pins)
//  H_ACTIVE      1024 active pixels per line
//  H_SYNC        136  hsync width, clocks
//  H_BACK        160  back porch, clocks
//  H_TOTAL       1344 expected clocks per line
//  H_TOL         2    allowed +/- deviation of measured line length
//  V_ACTIVE      768  active lines per frame
//  V_SYNC        6    vsync width, lines
//  V_BACK        29   back porch, lines
//  V_TOTAL       806  expected lines per frame (exact match required)
//  LOCK_FRAMES   3    consecutive good frames needed to assert lock
// PORTS
//  clk          in   1   pixel clock (65 MHz)
//  reset_n      in   1   synchronous reset, active low
//  hsync_in     in   1   raw horizontal sync, asynchronous to clk
//  vsync_in     in   1   raw vertical sync, asynchronous to clk
//  hcount       out  11  pixel column 0..H_ACTIVE-1 while active, else 0
//  vcount       out  10  line 0..V_ACTIVE-1 while active, else 0
//  active       out  1   in display area AND locked (inverse of blank)
//  frame_start  out  1   1-cycle pulse when v_pos returns to 0
//  locked       out  1   timing matches parameters
//  h_total      out  12  last measured clocks/line
//  v_total      out  11  last measured lines/frame
//  sync_err     out  1   1-cycle pulse on any timing violation while TRACK/LOCKED
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=SEARCH; internal counters 0. Applies mid-frame.
//  - Each sync: 2-flop synchronizer, XOR with SYNC_ACT_LOW, 1 prior-value flop.
//    hs_rise/vs_rise = registered pulse on deassert->assert transition.
//    hs_rise is high 3 cycles after the first clk edge that samples assertion.
//  - h_pos (12b): hs_rise ? 0 : saturating +1 (max 4095).
//    On hs_rise: h_total <= h_pos+1.
//  - v_pos (11b): vs_rise ? 0 : hs_rise ? +1 : hold; saturates at 2047.
//    vs_rise wins when both fire in the same cycle.
//    On vs_rise: v_total <= v_pos+1; frame_start pulses the next cycle.
//  - Window (registered, 1-cycle lag after h_pos/v_pos):
//    h_pos in [H_SYNC+H_BACK, +H_ACTIVE-1] = [296,1319]
//    and v_pos in [35,802] and locked.
//    In window: hcount=h_pos-296, vcount=v_pos-35, active=1.
//    Outside window: all three 0.
//  - line_bad: set at hs_rise if |h_pos+1 - H_TOTAL| > H_TOL; cleared at vs_rise.
//    frame_ok = !line_bad && (v_pos+1 == V_TOTAL), evaluated at vs_rise.
//  - FSM:
//    SEARCH: first vs_rise -> TRACK, good=0.
//    TRACK: at vs_rise, frame_ok ? good+1 : good=0 with sync_err.
//      good==LOCK_FRAMES -> LOCKED.
//    LOCKED: bad line at hs_rise, !frame_ok at vs_rise, or h_pos==4095
//      -> SEARCH with sync_err; locked falls the next cycle.
//    h_pos==4095 in TRACK (hsync lost) -> SEARCH with sync_err.
//  - locked = (state==LOCKED), registered.
//    Measurements (h_total/v_total) update in every state.
// TESTING
//  1 Nominal: 1344x806 active-low syncs, 4 frames -> locked high after 3rd
//    good vs_rise after the first; h_total=1344; v_total=806.
//    Per frame: 786432 active cycles; hcount 0..1023; vcount 0..767.
//  2 Jitter: lines alternating 1342/1346 while locked -> locked stays 1,
//    no sync_err.
//  3 Bad line: one 1350-clk line while locked -> sync_err pulse, locked=0,
//    active=0; relock after 3 further good frames.
//  4 Lost hsync: hsync held deasserted -> 4095 clks after last hs_rise,
//    sync_err pulse, locked=0, FSM=SEARCH.
//  5 Coincident vs_rise/hs_rise -> v_pos=0 (not 1), exactly one frame_start.
//    A 805-line frame -> unlock.
//  6 reset_n low 2 cycles mid-active-line -> next cycle all outputs 0;
//    relock needs full SEARCH/TRACK sequence.

Source files
------------

// File: rtl/xvga_sync_decoder.sv
// XVGA timing receiver: recovers pixel position from raw hsync/vsync,
// measures line/frame length and reports lock to the expected timing.
module xvga_sync_decoder #(
  parameter bit          SYNC_ACT_LOW = 1'b1,
  parameter int unsigned H_ACTIVE     = 1024,
  parameter int unsigned H_SYNC       = 136,
  parameter int unsigned H_BACK       = 160,
  parameter int unsigned H_TOTAL      = 1344,
  parameter int unsigned H_TOL        = 2,
  parameter int unsigned V_ACTIVE     = 768,
  parameter int unsigned V_SYNC       = 6,
  parameter int unsigned V_BACK       = 29,
  parameter int unsigned V_TOTAL      = 806,
  parameter int unsigned LOCK_FRAMES  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        active,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic        sync_err
);

  localparam int unsigned HPW = 12;
  localparam int unsigned VPW = 11;
  localparam int unsigned HLW = HPW + 1;
  localparam int unsigned VLW = VPW + 1;
  localparam int unsigned GW  = (LOCK_FRAMES > 2) ? $clog2(LOCK_FRAMES) : 1;

  localparam logic [HPW-1:0] H_MAX     = '1;
  localparam logic [VPW-1:0] V_MAX     = '1;
  localparam logic [HPW-1:0] H_WIN_LO  = HPW'(H_SYNC + H_BACK);
  localparam logic [HPW-1:0] H_WIN_HI  = HPW'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [VPW-1:0] V_WIN_LO  = VPW'(V_SYNC + V_BACK);
  localparam logic [VPW-1:0] V_WIN_HI  = VPW'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [HLW-1:0] H_LEN_MIN = HLW'(H_TOTAL - H_TOL);
  localparam logic [HLW-1:0] H_LEN_MAX = HLW'(H_TOTAL + H_TOL);
  localparam logic [VLW-1:0] V_LEN_EXP = VLW'(V_TOTAL);
  localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic           r_hs_meta, r_hs_sync, r_hs_cur, r_hs_prev, r_hs_rise;
  logic           r_vs_meta, r_vs_sync, r_vs_cur, r_vs_prev, r_vs_rise;
  logic [HPW-1:0] r_h_pos;
  logic [VPW-1:0] r_v_pos;
  logic           r_line_bad;
  state_t         r_state, w_state_nxt;
  logic [GW-1:0]  r_good, w_good_nxt;
  logic           w_err;

  logic [HLW-1:0] w_h_len;
  logic [VLW-1:0] w_v_len;
  logic           w_line_bad;
  logic           w_h_lost;
  logic           w_frame_ok;
  logic           w_in_win;

  // Synchronise, normalise polarity, and detect the assertion edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hs_meta <= SYNC_ACT_LOW;
      r_hs_sync <= SYNC_ACT_LOW;
      r_hs_cur  <= 1'b0;
      r_hs_prev <= 1'b0;
      r_hs_rise <= 1'b0;
      r_vs_meta <= SYNC_ACT_LOW;
      r_vs_sync <= SYNC_ACT_LOW;
      r_vs_cur  <= 1'b0;
      r_vs_prev <= 1'b0;
      r_vs_rise <= 1'b0;
    end else begin
      r_hs_meta <= hsync_in;
      r_hs_sync <= r_hs_meta;
      r_hs_cur  <= r_hs_sync ^ SYNC_ACT_LOW;
      r_hs_prev <= r_hs_cur;
      r_hs_rise <= r_hs_cur & ~r_hs_prev;
      r_vs_meta <= vsync_in;
      r_vs_sync <= r_vs_meta;
      r_vs_cur  <= r_vs_sync ^ SYNC_ACT_LOW;
      r_vs_prev <= r_vs_cur;
      r_vs_rise <= r_vs_cur & ~r_vs_prev;
    end
  end

  assign w_h_len    = {1'b0, r_h_pos} + HLW'(1);
  assign w_v_len    = {1'b0, r_v_pos} + VLW'(1);
  assign w_line_bad = (w_h_len < H_LEN_MIN) || (w_h_len > H_LEN_MAX);
  assign w_h_lost   = (r_h_pos == H_MAX);
  // The line closing at a coincident hs_rise still counts toward this frame.
  assign w_frame_ok = !(r_line_bad || (r_hs_rise && w_line_bad)) && (w_v_len == V_LEN_EXP);
  assign w_in_win   = (r_h_pos >= H_WIN_LO) && (r_h_pos <= H_WIN_HI) &&
                      (r_v_pos >= V_WIN_LO) && (r_v_pos <= V_WIN_HI) && locked;

  // Position counters and line/frame length measurement.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_h_pos     <= '0;
      r_v_pos     <= '0;
      r_line_bad  <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      frame_start <= 1'b0;
    end else begin
      if (r_hs_rise) begin
        r_h_pos <= '0;
        h_total <= 12'(w_h_len);
      end else if (!w_h_lost) begin
        r_h_pos <= r_h_pos + HPW'(1);
      end

      if (r_vs_rise) begin
        r_v_pos <= '0;
        v_total <= 11'(w_v_len);
      end else if (r_hs_rise && (r_v_pos != V_MAX)) begin
        r_v_pos <= r_v_pos + VPW'(1);
      end

      if (r_vs_rise) begin
        r_line_bad <= 1'b0;
      end else if (r_hs_rise && w_line_bad) begin
        r_line_bad <= 1'b1;
      end

      frame_start <= r_vs_rise;
    end
  end

  // Display window, one cycle behind the position counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      active <= w_in_win;
      hcount <= w_in_win ? 11'(r_h_pos - H_WIN_LO) : '0;
      vcount <= w_in_win ? 10'(r_v_pos - V_WIN_LO) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_SEARCH;
      r_good   <= '0;
      sync_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      sync_err <= w_err;
      locked   <= (r_state == ST_LOCKED);
    end
  end

  // Lock FSM: count consecutive good frames, drop out on any violation.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err       = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (r_vs_rise) begin
          w_state_nxt = ST_TRACK;
          w_good_nxt  = '0;
        end
      end
      ST_TRACK: begin
        if (w_h_lost) begin
          w_state_nxt = ST_SEARCH;
          w_err       = 1'b1;
        end else if (r_vs_rise) begin
          if (!w_frame_ok) begin
            w_good_nxt = '0;
            w_err      = 1'b1;
          end else if (r_good == GOOD_LAST) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_good_nxt = r_good + GW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (w_h_lost || (r_hs_rise && w_line_bad) || (r_vs_rise && !w_frame_ok)) begin
          w_state_nxt = ST_SEARCH;
          w_err       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

endmodule
